// File: rtl/sub_pkg.sv
// ============================================================================
// Module   : sub_pkg
// Purpose  : Shared state encoding and sizing helpers for sub_36b_serial.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 36;
  localparam int DIGIT_DEF = 4;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-digit datapath still needs a one-bit index register.
  function automatic int calc_idx_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

  localparam int IDX_W_DEF = calc_idx_w(calc_ndig(WIDTH_DEF, DIGIT_DEF));

endpackage

`default_nettype wire

// File: rtl/sub_36b_serial_nibble_sub.sv
// ============================================================================
// Module   : nibble_sub
// Purpose  : Combinational DIGIT-bit subtractor, d = a - b - bin, built as
//            a + ~b + ~bin so the carry-out is the inverted borrow.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nibble_sub #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] sum;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, ~b} + {{DIGIT{1'b0}}, ~bin};
    d    = sum[DIGIT-1:0];
    bout = ~sum[DIGIT];
  end

endmodule

`default_nettype wire

// File: rtl/sub_36b_serial.sv
// ============================================================================
// Module   : sub_36b_serial
// Purpose  : Digit-serial subtractor D = A - B - Bin, one DIGIT per clock,
//            with start/ready/done handshake. Optional macro: SUB_OVF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sub_36b_serial
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] D,
`ifdef SUB_OVF_EN
  output logic             OVF,
`endif
  output logic             Bout
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int IDX_W = calc_idx_w(NDIG);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               borrow_q, borrow_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               bout_q, bout_d;
`ifdef SUB_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [DIGIT-1:0]   dig_a, dig_b, dig_d;
  logic               dig_bout;

  // Single digit slice shared by every cycle of the operation.
  assign dig_a = a_q[idx_q*DIGIT +: DIGIT];
  assign dig_b = b_q[idx_q*DIGIT +: DIGIT];

  nibble_sub #(
    .DIGIT (DIGIT)
  ) u_nibble_sub (
    .a    (dig_a),
    .b    (dig_b),
    .bin  (borrow_q),
    .d    (dig_d),
    .bout (dig_bout)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    d_d      = d_q;
    bout_d   = bout_q;
`ifdef SUB_OVF_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          idx_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end

      RUN: begin
        d_d[idx_q*DIGIT +: DIGIT] = dig_d;
        borrow_d = dig_bout;
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          bout_d  = dig_bout;
`ifdef SUB_OVF_EN
          // The top digit is being produced this cycle, so its MSB is the result sign.
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ dig_d[DIGIT-1]);
`endif
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
`ifdef SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign ready = (state_q != RUN);
  assign done  = (state_q == DONE);
  assign D     = d_q;
  assign Bout  = bout_q;
`ifdef SUB_OVF_EN
  assign OVF   = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sub_36b_serial.sv
// ============================================================================
// Module   : tb_sub_36b_serial
// Purpose  : Scoreboard bench for sub_36b_serial (SUB_OVF_EN aware).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sub_36b_serial;

  localparam int NDIG = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [35:0] A, B, D;
  logic        Bin, ready, done, Bout;
`ifdef SUB_OVF_EN
  logic        OVF;
`endif

  sub_36b_serial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .ready (ready),
    .done  (done),
    .D     (D),
`ifdef SUB_OVF_EN
    .OVF   (OVF),
`endif
    .Bout  (Bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] d;
    logic        bout;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  int          pushed   = 0;
  logic [35:0] last_d   = '0;
  logic        last_b   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [36:0] model(input logic [35:0] a, input logic [35:0] b, input logic bi);
    return {1'b0, a} - {1'b0, b} - {36'd0, bi};
  endfunction

  // Monitor: pops one expected entry per done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && done === 1'b1) begin
        done_cnt++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 required no pending op (D=%0h)", D);
        end else begin
          e = sb.pop_front();
          check("D", D, e.d);
          check("Bout", Bout, e.bout);
`ifdef SUB_OVF_EN
          check("OVF", OVF, e.ovf);
`endif
          check("latency", cyc - e.acc, NDIG);
          check("ready_in_done", ready, 1);
          last_d = e.d;
          last_b = e.bout;
        end
      end
    end
  end

  task automatic issue(input logic [35:0] a, input logic [35:0] b, input logic bi,
                       input logic [35:0] ed, input logic eb, input logic eo, input bit push);
    int n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got ready=%b required 1", ready);
      return;
    end
    A = a; B = b; Bin = bi; start = 1'b1;
    if (push) begin
      sb.push_back('{ed, eb, eo, cyc + 1});
      pushed++;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    A = {4'($urandom), $urandom};
    B = {4'($urandom), $urandom};
    Bin = 1'($urandom_range(0, 1));
  endtask

  task automatic issue_rand();
    logic [35:0] a, b;
    logic        bi;
    logic [36:0] r;
    a  = {4'($urandom), $urandom};
    b  = {4'($urandom), $urandom};
    bi = 1'($urandom_range(0, 1));
    r  = model(a, b, bi);
    issue(a, b, bi, r[35:0], r[36], (a[35] ^ b[35]) & (a[35] ^ r[35]), 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || ready !== 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; A = 36'd5; B = 36'd3; Bin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_D", D, 0);
    check("rst_Bout", Bout, 0);
`ifdef SUB_OVF_EN
    check("rst_OVF", OVF, 0);
`endif
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready", ready, 1);

    // Basic op; ready must stay low across all RUN cycles.
    issue(36'h0_0000_0005, 36'h0_0000_0003, 1'b0, 36'h0_0000_0002, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < NDIG; i++) begin
      @(negedge clk);
      check("ready_run", ready, 0);
    end
    wait_idle();

    issue(36'h0_0000_0000, 36'h0_0000_0001, 1'b0, 36'hF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
    issue(36'h1_2345_6789, 36'h1_2345_6789, 1'b1, 36'hF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
    issue(36'h9_8765_4321, 36'h9_8765_4321, 1'b0, 36'h0_0000_0000, 1'b0, 1'b0, 1'b1);
    issue(36'h0_0000_0000, 36'hF_FFFF_FFFF, 1'b1, 36'h0_0000_0000, 1'b1, 1'b0, 1'b1);
    issue(36'h8_0000_0000, 36'h0_0000_0001, 1'b0, 36'h7_FFFF_FFFF, 1'b0, 1'b1, 1'b1);
    wait_idle();

    // Reset in the 4th RUN cycle aborts the op without a done pulse.
    issue(36'hA_AAAA_AAAA, 36'h5_5555_5555, 1'b0, 36'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_D", D, 0);
    check("abort_Bout", Bout, 0);
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    rst_n = 1'b1;
    issue(36'hA_AAAA_AAAA, 36'h5_5555_5555, 1'b0, 36'h5_5555_5555, 1'b0, 1'b1, 1'b1);
    wait_idle();

    // start pulsed mid-RUN with different operands must be ignored.
    issue(36'h0_0000_1000, 36'h0_0000_0001, 1'b1, 36'h0_0000_0FFE, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    A = 36'hF_0000_0000; B = 36'h0_1234_0000; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Back-to-back: second start lands in the DONE cycle of the first.
    issue(36'h0_0000_0001, 36'h0_0000_0002, 1'b0, 36'hF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
    issue(36'h7_FFFF_FFFF, 36'hF_FFFF_FFFF, 1'b0, 36'h8_0000_0000, 1'b1, 1'b1, 1'b1);
    issue(36'h0_0000_0005, 36'h0_0000_0003, 1'b0, 36'h0_0000_0002, 1'b0, 1'b0, 1'b1);
    wait_idle();

    for (int i = 0; i < 1000; i++) issue_rand();
    wait_idle();

    repeat (3) @(negedge clk);
    check("hold_D", D, last_d);
    check("hold_Bout", Bout, last_b);
    check("done_count", done_cnt, pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
